// File: rtl/alu_mx.sv
// alu_mx: RV32I/RV32M execution unit between reservation station and ROB/CDB.
// Base ops finish in one cycle, MUL* in two, DIV*/REM* iterate one bit per enabled edge.
module alu_mx #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 4,
  parameter int OP_WIDTH  = 6,
  parameter int MUL_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_valid,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 in_clear,
  output logic                 out_busy,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_value,
  output logic [XLEN-1:0]      out_newpc,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(6'd0);
  localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(6'd1);
  localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(6'd2);
  localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(6'd3);
  localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(6'd4);
  localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(6'd5);
  localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(6'd6);
  localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(6'd7);
  localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(6'd8);
  localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(6'd9);
  localparam logic [OP_WIDTH-1:0] OP_ADDI   = OP_WIDTH'(6'd10);
  localparam logic [OP_WIDTH-1:0] OP_SLTI   = OP_WIDTH'(6'd11);
  localparam logic [OP_WIDTH-1:0] OP_SLTIU  = OP_WIDTH'(6'd12);
  localparam logic [OP_WIDTH-1:0] OP_XORI   = OP_WIDTH'(6'd13);
  localparam logic [OP_WIDTH-1:0] OP_ORI    = OP_WIDTH'(6'd14);
  localparam logic [OP_WIDTH-1:0] OP_ANDI   = OP_WIDTH'(6'd15);
  localparam logic [OP_WIDTH-1:0] OP_SLLI   = OP_WIDTH'(6'd16);
  localparam logic [OP_WIDTH-1:0] OP_SRLI   = OP_WIDTH'(6'd17);
  localparam logic [OP_WIDTH-1:0] OP_SRAI   = OP_WIDTH'(6'd18);
  localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(6'd19);
  localparam logic [OP_WIDTH-1:0] OP_AUIPC  = OP_WIDTH'(6'd20);
  localparam logic [OP_WIDTH-1:0] OP_BEQ    = OP_WIDTH'(6'd21);
  localparam logic [OP_WIDTH-1:0] OP_BNE    = OP_WIDTH'(6'd22);
  localparam logic [OP_WIDTH-1:0] OP_BLT    = OP_WIDTH'(6'd23);
  localparam logic [OP_WIDTH-1:0] OP_BGE    = OP_WIDTH'(6'd24);
  localparam logic [OP_WIDTH-1:0] OP_BLTU   = OP_WIDTH'(6'd25);
  localparam logic [OP_WIDTH-1:0] OP_BGEU   = OP_WIDTH'(6'd26);
  localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(6'd27);
  localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(6'd28);
  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(6'd32);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(6'd33);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(6'd34);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(6'd35);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(6'd36);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(6'd37);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(6'd38);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(6'd39);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_t;

  state_t                state_r, state_nx_s;
  logic [2*XLEN-1:0]     prod_r;
  logic                  mul_hi_r;
  logic [XLEN-1:0]       div_rem_r, div_dvd_r, div_dvs_r;
  logic                  div_qneg_r, div_rneg_r, div_zero_r, div_want_rem_r;
  logic [CW-1:0]         div_cnt_r;

  logic [XLEN-1:0]       sc_value_s, sc_newpc_s;
  logic                  is_mul_s, is_div_s, mul_hi_s, mul_sa_s, mul_sb_s;
  logic                  div_signed_s, div_want_rem_s, div_aneg_s, div_bneg_s;
  logic [XLEN-1:0]       div_amag_s, div_bmag_s;
  logic [2*XLEN-1:0]     mul_a_s, mul_b_s, mul_prod_s;
  logic [XLEN:0]         div_part_s;
  logic                  div_ge_s;
  logic [XLEN-1:0]       div_sub_s, div_rem_nx_s, div_q_nx_s, div_quo_s, div_rmd_s;

  assign out_busy = (state_r != ST_IDLE);

  // Base-ISA result and branch/jump target for the operation on the issue port
  always_comb begin
    sc_value_s = {XLEN{1'b0}};
    sc_newpc_s = {XLEN{1'b0}};
    case (in_op)
      OP_ADD:   sc_value_s = in_rs1 + in_rs2;
      OP_SUB:   sc_value_s = in_rs1 - in_rs2;
      OP_SLL:   sc_value_s = in_rs1 << in_rs2[SHW-1:0];
      OP_SLT:   sc_value_s = XLEN'($signed(in_rs1) < $signed(in_rs2));
      OP_SLTU:  sc_value_s = XLEN'(in_rs1 < in_rs2);
      OP_XOR:   sc_value_s = in_rs1 ^ in_rs2;
      OP_SRL:   sc_value_s = in_rs1 >> in_rs2[SHW-1:0];
      OP_SRA:   sc_value_s = $unsigned($signed(in_rs1) >>> in_rs2[SHW-1:0]);
      OP_OR:    sc_value_s = in_rs1 | in_rs2;
      OP_AND:   sc_value_s = in_rs1 & in_rs2;
      OP_ADDI:  sc_value_s = in_rs1 + in_imm;
      OP_SLTI:  sc_value_s = XLEN'($signed(in_rs1) < $signed(in_imm));
      OP_SLTIU: sc_value_s = XLEN'(in_rs1 < in_imm);
      OP_XORI:  sc_value_s = in_rs1 ^ in_imm;
      OP_ORI:   sc_value_s = in_rs1 | in_imm;
      OP_ANDI:  sc_value_s = in_rs1 & in_imm;
      OP_SLLI:  sc_value_s = in_rs1 << in_imm[SHW-1:0];
      OP_SRLI:  sc_value_s = in_rs1 >> in_imm[SHW-1:0];
      OP_SRAI:  sc_value_s = $unsigned($signed(in_rs1) >>> in_imm[SHW-1:0]);
      OP_LUI:   sc_value_s = in_imm;
      OP_AUIPC: sc_value_s = in_pc + in_imm;
      OP_BEQ:   begin sc_value_s = XLEN'(in_rs1 == in_rs2); sc_newpc_s = in_pc + in_imm; end
      OP_BNE:   begin sc_value_s = XLEN'(in_rs1 != in_rs2); sc_newpc_s = in_pc + in_imm; end
      OP_BLT:   begin sc_value_s = XLEN'($signed(in_rs1) < $signed(in_rs2)); sc_newpc_s = in_pc + in_imm; end
      OP_BGE:   begin sc_value_s = XLEN'($signed(in_rs1) >= $signed(in_rs2)); sc_newpc_s = in_pc + in_imm; end
      OP_BLTU:  begin sc_value_s = XLEN'(in_rs1 < in_rs2); sc_newpc_s = in_pc + in_imm; end
      OP_BGEU:  begin sc_value_s = XLEN'(in_rs1 >= in_rs2); sc_newpc_s = in_pc + in_imm; end
      OP_JAL:   sc_value_s = in_pc + PC_STEP;
      OP_JALR:  begin
        sc_value_s = in_pc + PC_STEP;
        sc_newpc_s = (in_rs1 + in_imm) & ~XLEN'(1'b1);
      end
      default:  sc_value_s = {XLEN{1'b0}};
    endcase
  end

  // M-extension decode; with MUL_EN=0 these ops fall through to the zero-result path
  always_comb begin
    is_mul_s       = 1'b0;
    is_div_s       = 1'b0;
    mul_hi_s       = 1'b0;
    mul_sa_s       = 1'b0;
    mul_sb_s       = 1'b0;
    div_signed_s   = 1'b0;
    div_want_rem_s = 1'b0;
    if (MUL_EN != 0) begin
      case (in_op)
        OP_MUL:    is_mul_s = 1'b1;
        OP_MULH:   begin is_mul_s = 1'b1; mul_hi_s = 1'b1; mul_sa_s = 1'b1; mul_sb_s = 1'b1; end
        OP_MULHSU: begin is_mul_s = 1'b1; mul_hi_s = 1'b1; mul_sa_s = 1'b1; end
        OP_MULHU:  begin is_mul_s = 1'b1; mul_hi_s = 1'b1; end
        OP_DIV:    begin is_div_s = 1'b1; div_signed_s = 1'b1; end
        OP_DIVU:   is_div_s = 1'b1;
        OP_REM:    begin is_div_s = 1'b1; div_signed_s = 1'b1; div_want_rem_s = 1'b1; end
        OP_REMU:   begin is_div_s = 1'b1; div_want_rem_s = 1'b1; end
        default:   is_mul_s = 1'b0;
      endcase
    end else begin
      is_mul_s = 1'b0;
    end
  end

  assign mul_a_s    = {{XLEN{mul_sa_s & in_rs1[XLEN-1]}}, in_rs1};
  assign mul_b_s    = {{XLEN{mul_sb_s & in_rs2[XLEN-1]}}, in_rs2};
  assign mul_prod_s = mul_a_s * mul_b_s;

  assign div_aneg_s = div_signed_s & in_rs1[XLEN-1];
  assign div_bneg_s = div_signed_s & in_rs2[XLEN-1];
  assign div_amag_s = div_aneg_s ? ({XLEN{1'b0}} - in_rs1) : in_rs1;
  assign div_bmag_s = div_bneg_s ? ({XLEN{1'b0}} - in_rs2) : in_rs2;

  // One restoring step: the partial remainder can exceed XLEN bits before the subtract
  assign div_part_s   = {div_rem_r, div_dvd_r[XLEN-1]};
  assign div_ge_s     = (div_part_s >= {1'b0, div_dvs_r});
  assign div_sub_s    = div_part_s[XLEN-1:0] - div_dvs_r;
  assign div_rem_nx_s = div_ge_s ? div_sub_s : div_part_s[XLEN-1:0];
  assign div_q_nx_s   = {div_dvd_r[XLEN-2:0], div_ge_s};
  assign div_quo_s    = div_zero_r ? {XLEN{1'b1}}
                      : (div_qneg_r ? ({XLEN{1'b0}} - div_q_nx_s) : div_q_nx_s);
  assign div_rmd_s    = div_rneg_r ? ({XLEN{1'b0}} - div_rem_nx_s) : div_rem_nx_s;

  // Next-state: flush wins, then issue from IDLE, then multi-cycle completion
  always_comb begin
    state_nx_s = state_r;
    if (!rdy) begin
      state_nx_s = state_r;
    end else if (in_clear) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && is_mul_s) begin
            state_nx_s = ST_MUL;
          end else if (in_valid && is_div_s) begin
            state_nx_s = ST_DIV;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_MUL:  state_nx_s = ST_IDLE;
        ST_DIV:  state_nx_s = (div_cnt_r == CNT_ONE) ? ST_IDLE : ST_DIV;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Datapath and result registers; rdy low freezes everything including out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_value      <= {XLEN{1'b0}};
      out_newpc      <= {XLEN{1'b0}};
      out_tag        <= {TAG_WIDTH{1'b0}};
      prod_r         <= {(2*XLEN){1'b0}};
      mul_hi_r       <= 1'b0;
      div_rem_r      <= {XLEN{1'b0}};
      div_dvd_r      <= {XLEN{1'b0}};
      div_dvs_r      <= {XLEN{1'b0}};
      div_qneg_r     <= 1'b0;
      div_rneg_r     <= 1'b0;
      div_zero_r     <= 1'b0;
      div_want_rem_r <= 1'b0;
      div_cnt_r      <= {CW{1'b0}};
    end else if (rdy) begin
      if (in_clear) begin
        out_valid <= 1'b0;
        div_cnt_r <= {CW{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: begin
            out_valid <= 1'b0;
            if (in_valid) begin
              out_tag <= in_tag;
              if (is_mul_s) begin
                prod_r   <= mul_prod_s;
                mul_hi_r <= mul_hi_s;
              end else if (is_div_s) begin
                div_rem_r      <= {XLEN{1'b0}};
                div_dvd_r      <= div_amag_s;
                div_dvs_r      <= div_bmag_s;
                div_qneg_r     <= div_aneg_s ^ div_bneg_s;
                div_rneg_r     <= div_aneg_s;
                div_zero_r     <= (in_rs2 == {XLEN{1'b0}});
                div_want_rem_r <= div_want_rem_s;
                div_cnt_r      <= CNT_LOAD;
              end else begin
                out_valid <= 1'b1;
                out_value <= sc_value_s;
                out_newpc <= sc_newpc_s;
              end
            end
          end
          ST_MUL: begin
            out_valid <= 1'b1;
            out_value <= mul_hi_r ? prod_r[2*XLEN-1:XLEN] : prod_r[XLEN-1:0];
            out_newpc <= {XLEN{1'b0}};
          end
          ST_DIV: begin
            div_rem_r <= div_rem_nx_s;
            div_dvd_r <= div_q_nx_s;
            div_cnt_r <= div_cnt_r - CNT_ONE;
            if (div_cnt_r == CNT_ONE) begin
              out_valid <= 1'b1;
              out_value <= div_want_rem_r ? div_rmd_s : div_quo_s;
              out_newpc <= {XLEN{1'b0}};
            end else begin
              out_valid <= 1'b0;
            end
          end
          default: out_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mx.sv
// Self-checking bench for alu_mx: directed vector table, randomized ops against
// an arithmetic reference model, and hand sequences for busy/flush/stall/reset.
module tb_alu_mx;

  localparam int XLEN = 32;
  localparam int DLAT = XLEN + 1;

  localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_SLL = 6'd2,  OP_SLT = 6'd3;
  localparam logic [5:0] OP_SLTU = 6'd4, OP_XOR = 6'd5,  OP_SRL = 6'd6,  OP_SRA = 6'd7;
  localparam logic [5:0] OP_OR = 6'd8,   OP_AND = 6'd9,  OP_ADDI = 6'd10, OP_SLTI = 6'd11;
  localparam logic [5:0] OP_SLTIU = 6'd12, OP_XORI = 6'd13, OP_ORI = 6'd14, OP_ANDI = 6'd15;
  localparam logic [5:0] OP_SLLI = 6'd16, OP_SRLI = 6'd17, OP_SRAI = 6'd18, OP_LUI = 6'd19;
  localparam logic [5:0] OP_AUIPC = 6'd20, OP_BEQ = 6'd21, OP_BNE = 6'd22, OP_BLT = 6'd23;
  localparam logic [5:0] OP_BGE = 6'd24, OP_BLTU = 6'd25, OP_BGEU = 6'd26, OP_JAL = 6'd27;
  localparam logic [5:0] OP_JALR = 6'd28, OP_MUL = 6'd32, OP_MULH = 6'd33, OP_MULHSU = 6'd34;
  localparam logic [5:0] OP_MULHU = 6'd35, OP_DIV = 6'd36, OP_DIVU = 6'd37, OP_REM = 6'd38;
  localparam logic [5:0] OP_REMU = 6'd39;

  logic        clk = 1'b0;
  logic        rst, rdy, in_valid, in_clear;
  logic [5:0]  in_op;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [3:0]  in_tag;
  logic        out_busy, out_valid;
  logic [31:0] out_value, out_newpc;
  logic [3:0]  out_tag;

  int tests = 0;
  int fails = 0;

  alu_mx dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .in_tag(in_tag), .in_clear(in_clear), .out_busy(out_busy),
    .out_valid(out_valid), .out_value(out_value), .out_newpc(out_newpc),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, imm, pc;
    logic [31:0] ev, en;
    int          lat;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference results straight from the ISA definitions using wide integer arithmetic
  function automatic void ref_model(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                                    output logic [31:0] v, output logic [31:0] n, output int lat);
    longint          sa, sb, si;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    si = longint'($signed(imm));
    ua = {32'd0, a};
    ub = {32'd0, b};
    v = 32'd0; n = 32'd0; lat = 1;
    case (op)
      OP_ADD:   v = a + b;
      OP_SUB:   v = a - b;
      OP_SLL:   v = a << b[4:0];
      OP_SLT:   v = {31'd0, sa < sb};
      OP_SLTU:  v = {31'd0, a < b};
      OP_XOR:   v = a ^ b;
      OP_SRL:   v = a >> b[4:0];
      OP_SRA:   begin p = 64'(sa >>> b[4:0]); v = p[31:0]; end
      OP_OR:    v = a | b;
      OP_AND:   v = a & b;
      OP_ADDI:  v = a + imm;
      OP_SLTI:  v = {31'd0, sa < si};
      OP_SLTIU: v = {31'd0, a < imm};
      OP_XORI:  v = a ^ imm;
      OP_ORI:   v = a | imm;
      OP_ANDI:  v = a & imm;
      OP_SLLI:  v = a << imm[4:0];
      OP_SRLI:  v = a >> imm[4:0];
      OP_SRAI:  begin p = 64'(sa >>> imm[4:0]); v = p[31:0]; end
      OP_LUI:   v = imm;
      OP_AUIPC: v = pc + imm;
      OP_BEQ:   begin v = {31'd0, a == b};  n = pc + imm; end
      OP_BNE:   begin v = {31'd0, a != b};  n = pc + imm; end
      OP_BLT:   begin v = {31'd0, sa < sb}; n = pc + imm; end
      OP_BGE:   begin v = {31'd0, sa >= sb}; n = pc + imm; end
      OP_BLTU:  begin v = {31'd0, a < b};   n = pc + imm; end
      OP_BGEU:  begin v = {31'd0, a >= b};  n = pc + imm; end
      OP_JAL:   v = pc + 32'd4;
      OP_JALR:  begin v = pc + 32'd4; n = (a + imm) & 32'hFFFF_FFFE; end
      OP_MUL:    begin p = 64'(sa * sb); v = p[31:0];  lat = 2; end
      OP_MULH:   begin p = 64'(sa * sb); v = p[63:32]; lat = 2; end
      OP_MULHSU: begin p = 64'(sa * ub); v = p[63:32]; lat = 2; end
      OP_MULHU:  begin p = 64'(ua * ub); v = p[63:32]; lat = 2; end
      OP_DIV: begin
        lat = DLAT;
        if (b == 32'd0) v = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) v = a;
        else begin p = 64'(sa / sb); v = p[31:0]; end
      end
      OP_DIVU: begin
        lat = DLAT;
        if (b == 32'd0) v = 32'hFFFF_FFFF;
        else begin p = 64'(ua / ub); v = p[31:0]; end
      end
      OP_REM: begin
        lat = DLAT;
        if (b == 32'd0) v = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) v = 32'd0;
        else begin p = 64'(sa % sb); v = p[31:0]; end
      end
      OP_REMU: begin
        lat = DLAT;
        if (b == 32'd0) v = a;
        else begin p = 64'(ua % ub); v = p[31:0]; end
      end
      default: begin v = 32'd0; n = 32'd0; lat = 1; end
    endcase
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] a, b, imm, pc, input logic [3:0] tag);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_imm = imm; in_pc = pc; in_tag = tag;
  endtask

  // Issue one op and check result timing, busy, value, target, tag and single-pulse
  task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                        input logic [3:0] tag, input logic [31:0] ev, en, input int lat);
    int cyc;
    bit got;
    @(negedge clk);
    drive(op, a, b, imm, pc, tag);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc <= lat + 4) begin
      if (out_valid === 1'b1) begin
        got = 1'b1;
        chk({nm, "_latency"}, 32'(cyc), 32'(lat));
        chk({nm, "_value"}, out_value, ev);
        chk({nm, "_newpc"}, out_newpc, en);
        chk({nm, "_tag"}, {28'd0, out_tag}, {28'd0, tag});
        chk({nm, "_busy_at_result"}, {31'd0, out_busy}, 32'd0);
      end else begin
        if (cyc == 1) chk({nm, "_busy"}, {31'd0, out_busy}, {31'd0, lat > 1});
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk({nm, "_pulse"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    int          cyc, pulses;
    bit          got;
    logic [31:0] ev, en, a, b;
    logic [31:0] specials[5];
    logic [5:0]  op;
    int          lat;

    vt[0]  = '{OP_ADD,    32'hFFFF_FFFF, 32'd1,         32'd0,  32'd0,     32'd0,         32'd0,     1};
    vt[1]  = '{OP_SRA,    32'h8000_0000, 32'h0000_0021, 32'd0,  32'd0,     32'hC000_0000, 32'd0,     1};
    vt[2]  = '{OP_JALR,   32'h0000_1001, 32'd0,         32'd4,  32'h100,   32'h0000_0104, 32'h1004,  1};
    vt[3]  = '{OP_BLT,    32'hFFFF_FFFF, 32'd1,         32'h20, 32'h200,   32'd1,         32'h220,   1};
    vt[4]  = '{OP_BGEU,   32'hFFFF_FFFF, 32'd1,         32'h10, 32'h300,   32'd1,         32'h310,   1};
    vt[5]  = '{OP_BEQ,    32'd5,         32'd6,         32'h40, 32'h400,   32'd0,         32'h440,   1};
    vt[6]  = '{OP_LUI,    32'd0,         32'd0,         32'hABCD_E000, 32'd0, 32'hABCD_E000, 32'd0,  1};
    vt[7]  = '{OP_JAL,    32'd0,         32'd0,         32'h80, 32'h500,   32'h504,       32'd0,     1};
    vt[8]  = '{6'd30,     32'h1234,      32'h5678,      32'd1,  32'h600,   32'd0,         32'd0,     1};
    vt[9]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'd0,  32'd0,     32'h4000_0000, 32'd0,     2};
    vt[10] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'd0,     32'hFFFF_FFFE, 32'd0,     2};
    vt[11] = '{OP_MUL,    32'h0001_0000, 32'h0001_0001, 32'd0,  32'd0,     32'h0001_0000, 32'd0,     2};
    vt[12] = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'd0,  32'd0,     32'hFFFF_FFFD, 32'd0,     DLAT};
    vt[13] = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'd0,  32'd0,     32'hFFFF_FFFF, 32'd0,     DLAT};
    vt[14] = '{OP_DIVU,   32'h1234,      32'd0,         32'd0,  32'd0,     32'hFFFF_FFFF, 32'd0,     DLAT};
    vt[15] = '{OP_REM,    32'hFFFF_FFF0, 32'd0,         32'd0,  32'd0,     32'hFFFF_FFF0, 32'd0,     DLAT};
    vt[16] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,  32'd0,     32'h8000_0000, 32'd0,     DLAT};
    vt[17] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,  32'd0,     32'd0,         32'd0,     DLAT};

    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_clear = 1'b0;
    in_op = 6'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_imm = 32'd0; in_pc = 32'd0; in_tag = 4'd0;
    #12;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, out_busy}, 32'd0);
    chk("reset_value", out_value, 32'd0);
    chk("reset_newpc", out_newpc, 32'd0);
    chk("reset_tag", {28'd0, out_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].pc,
             4'(i + 1), vt[i].ev, vt[i].en, vt[i].lat);
    end

    for (int i = 0; i < 60; i++) begin
      op = 6'($urandom_range(0, 39));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      in_imm = 32'($urandom);
      in_pc  = 32'($urandom) & 32'hFFFF_FFFC;
      ref_model(op, a, b, in_imm, in_pc, ev, en, lat);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, in_imm, in_pc, 4'($urandom), ev, en, lat);
    end

    // in_valid held during busy must not be accepted
    @(negedge clk);
    drive(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'hA);
    @(posedge clk);
    @(negedge clk);
    chk("busyign_busy", {31'd0, out_busy}, 32'd1);
    drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'h5);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busyign_valid", {31'd0, out_valid}, 32'd1);
    chk("busyign_value", out_value, 32'hFFFF_FFFE);
    chk("busyign_tag", {28'd0, out_tag}, 32'hA);
    @(negedge clk);
    chk("busyign_no_extra", {31'd0, out_valid}, 32'd0);

    // flush mid-DIV, with a same-cycle issue that must be discarded
    @(negedge clk);
    drive(OP_DIV, 32'd1000, 32'd7, 32'd0, 32'd0, 4'h3);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    in_clear = 1'b1;
    drive(OP_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 4'h9);
    @(posedge clk);
    @(negedge clk);
    in_clear = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", {31'd0, out_busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("flush_no_result", 32'(pulses), 32'd0);
    run_op("after_flush_add", OP_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 4'h6, 32'd7, 32'd0, 1);

    // rdy low for 5 cycles mid-DIV stretches latency by 5, and rdy low holds out_valid
    @(negedge clk);
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 4'h7);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc <= 50) begin
      if (cyc == 5) rdy = 1'b0;
      if (cyc == 10) rdy = 1'b1;
      if (cyc == 7) chk("stall_busy", {31'd0, out_busy}, 32'd1);
      if (out_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("stall_latency", 32'(cyc), 32'(DLAT + 5));
    chk("stall_value", out_value, 32'hFFFF_FFFD);
    rdy = 1'b0;
    @(negedge clk);
    chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", {31'd0, out_valid}, 32'd0);

    // asynchronous reset in the middle of a MUL
    run_op("pre_reset_jalr", OP_JALR, 32'h2001, 32'd0, 32'd8, 32'h40, 4'hC, 32'h44, 32'h2008, 1);
    @(negedge clk);
    drive(OP_MUL, 32'd3, 32'd5, 32'd0, 32'd0, 4'hE);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, out_busy}, 32'd0);
    chk("rst_value", out_value, 32'd0);
    chk("rst_newpc", out_newpc, 32'd0);
    chk("rst_tag", {28'd0, out_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("rst_no_result", 32'(pulses), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mx.md
# alu_mx

Parametrised successor to the single-cycle integer ALU. It keeps the full RV32I integer/branch/jump operation set at one-cycle latency and adds the RV32M multiply (2-cycle) and divide/remainder (iterative, XLEN+1 cycles) operations. Issue uses a valid/busy handshake, and a flush input supports misprediction rollback. The block sits between the reservation station and the ROB/CDB broadcast. Results are tagged with the ROB entry.

## Interface
- XLEN, 32, datapath width (≥8, power of two)
- TAG_WIDTH, 4, ROB tag width
- OP_WIDTH, 6, internal opcode width (codes from the shared constant header, including the new MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- MUL_EN, 1, 1 = M-extension ops supported; 0 = M ops complete single-cycle with value 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low freezes all state and outputs
- in_valid  in  1  issue strobe from reservation station
- in_op  in  OP_WIDTH  internal opcode
- in_rs1, in_rs2, in_imm, in_pc  in  XLEN each  operands, immediate, instruction PC
- in_tag  in  TAG_WIDTH  ROB tag
- in_clear  in  1  flush: abort in-flight op, drop pending result
- out_busy  out  1  high while a MUL/DIV is in flight; issue is not allowed
- out_valid  out  1  one-cycle result strobe
- out_value  out  XLEN  rd value (branch: taken = 1 / not taken = 0)
- out_newpc  out  XLEN  branch/JALR target; 0 for other ops
- out_tag  out  TAG_WIDTH  tag of the result

## Operation
- **States:** IDLE, MUL, DIV. `out_busy = (state != IDLE)` is combinational.
- **Issue:** an instruction is accepted on a rising edge with rdy=1, in_valid=1, state=IDLE and in_clear=0. When out_busy=1, in_valid is ignored, and the RS must hold the instruction.
- **Single-cycle ops** use the base opcode set:
  - Registered result; state stays IDLE.
  - Shift amount is the low log2(XLEN) bits of rs2/imm. SRA/SRAI are arithmetic (signed).
  - Branch target is pc+imm. JAL gives value pc+4.
  - JALR gives value pc+4 and newpc (rs1+imm) with bit 0 cleared.
  - An unknown opcode gives value 0, newpc 0, and out_valid still pulses.
- **MUL\* ops:**
  - Accept → state MUL, latching the full 2·XLEN product with signedness per op.
  - Next enabled edge: emit the low half (MUL) or the high half (MULH/MULHSU/MULHU) → IDLE.
- **DIV\* / REM\* ops:**
  - Accept → state DIV. Latch the operand magnitudes (signed ops), the result signs and a counter = XLEN.
  - Each enabled edge performs one restoring shift-subtract step, producing one quotient bit and decrementing the counter.
  - At counter 1 the final step completes: apply sign fixup, emit the quotient or remainder, and go to IDLE.
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0.
- **out_tag** is the tag latched at accept.
- **in_clear** (with rdy=1) has priority over everything:
  - state → IDLE, out_valid → 0, counter cleared.
  - The same-cycle in_valid is discarded.
- **rdy=0:** no register changes. out_valid holds its value and the consumer is frozen too.

## Timing
- **Reset values:** state IDLE, out_valid 0, out_value 0, out_newpc 0, out_tag 0, counter 0, out_busy 0.
- **Latencies**, with accept at edge N and all edges enabled:
  - Single-cycle ops: out_valid high for cycle N+1.
  - MUL ops: out_busy high N+1; out_valid high N+2.
  - DIV ops: out_busy high N+1…N+XLEN; out_valid high N+XLEN+1.
- A new op may be accepted at the edge that starts the result cycle (out_busy already low), so results never collide.
- rdy low for k cycles stretches every latency by exactly k.
- out_valid is a single-cycle pulse per accepted, non-flushed instruction.
- An asynchronous reset mid-DIV returns to the reset values immediately, and no result is emitted.

## Test plan
- **Single-cycle ops:**
  - ADD 0xFFFFFFFF+1 → out_value 0 at N+1 with tag preserved.
  - SRA 0x80000000 by rs2=0x21 → 0xC0000000 (shift amount 1).
  - JALR rs1=0x1001, imm=4, pc=0x100 → value 0x104, newpc 0x1004.
- **Branches:**
  - BLT −1 vs 1 → value 1, newpc pc+imm.
  - BGEU 0xFFFFFFFF vs 1 → value 1.
- **MUL:**
  - MULH 0x80000000×0x80000000 → 0x40000000 at N+2, out_busy high N+1.
  - MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
  - in_valid during busy is ignored.
- **DIV / REM:**
  - DIV −7/2 → −3 and REM −7/2 → −1 at N+33.
  - DIVU x/0 → 0xFFFFFFFF; REM x/0 → x.
  - DIV 0x80000000/−1 → 0x80000000, REM → 0.
- **Flush:**
  - in_clear at N+10 of a DIV → no out_valid, out_busy low from N+11.
  - An ADD accepted at N+11 gives its result at N+12.
- **Stall / reset:**
  - rdy low 5 cycles mid-DIV → result at N+38, value correct.
  - rst pulse mid-MUL → all outputs 0, state IDLE, no result pulse.
